// File: rtl/lcd_fmt_pkg.sv
// lcd_fmt_pkg -- shared constants for the LCD1602 row formatter.
//   Holds the FSM state encoding, the ASCII bytes used to build the rows,
//   the channel label bytes and the row length in characters.
package lcd_fmt_pkg;

   localparam int ROW_CHARS = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONV_A = 2'd1,
      ST_CONV_B = 2'd2,
      ST_UPDATE = 2'd3
   } fmt_state_e;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_C     = 8'h43;
   localparam logic [7:0] ASCII_H     = 8'h48;
   localparam logic [7:0] ASCII_COLON = 8'h3A;
   localparam logic [7:0] ASCII_ONE   = 8'h31;
   localparam logic [7:0] ASCII_TWO   = 8'h32;

   // Four-character labels occupying chars 0-3 of each row.
   localparam logic [31:0] LABEL_CH1 = {ASCII_C, ASCII_H, ASCII_ONE, ASCII_COLON};
   localparam logic [31:0] LABEL_CH2 = {ASCII_C, ASCII_H, ASCII_TWO, ASCII_COLON};

endpackage : lcd_fmt_pkg

// File: rtl/bcd_add3_adj.sv
// bcd_add3_adj -- double-dabble correction stage (purely combinational).
//   Every BCD nibble that is >= 5 gets +3 so the following left shift
//   carries correctly into the next decimal digit.
// Ports:
//   bcd_i  in   4*DIGITS  packed BCD digits, least significant nibble at [3:0]
//   bcd_o  out  4*DIGITS  corrected digits
module bcd_add3_adj #(
   parameter int DIGITS = 5
) (
   input  logic [4*DIGITS-1:0] bcd_i,
   output logic [4*DIGITS-1:0] bcd_o
);

   // Per-nibble add-3 correction.
   always_comb begin
      bcd_o = bcd_i;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_i[4*i +: 4] >= 4'd5) begin
            bcd_o[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
         end else begin
            bcd_o[4*i +: 4] = bcd_i[4*i +: 4];
         end
      end
   end

endmodule : bcd_add3_adj

// File: rtl/lcd_bin2ascii_fmt.sv
// lcd_bin2ascii_fmt -- converts two unsigned binary values to decimal with a
//   sequential double-dabble (one bit per clock, channel A then channel B) and
//   formats two 16-character ASCII rows "CH1:ddddd" / "CH2:ddddd".
//   Both rows are written on the same edge so the LCD scan never shows a
//   half-updated pair.
// Ports:
//   clk       in   1    system clock (LCD driver domain)
//   rst_n     in   1    asynchronous active-low reset
//   start     in   1    conversion request, honoured only when idle
//   bin_a     in   16   channel 1 value
//   bin_b     in   16   channel 2 value
//   row1_val  out  128  row 1 ASCII, char 0 in [127:120]
//   row2_val  out  128  row 2 ASCII, same packing
//   busy      out  1    conversion in progress
//   done      out  1    one-cycle pulse with the new row values
module lcd_bin2ascii_fmt
   import lcd_fmt_pkg::*;
#(
   parameter int BIN_W    = 16,
   parameter int DIGITS   = 5,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [BIN_W-1:0]       bin_a,
   input  logic [BIN_W-1:0]       bin_b,
   output logic [8*ROW_CHARS-1:0] row1_val,
   output logic [8*ROW_CHARS-1:0] row2_val,
   output logic                   busy,
   output logic                   done
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W);
   localparam int ROW_W = 8 * ROW_CHARS;

   fmt_state_e         state_q, state_d;
   logic [BIN_W-1:0]   bin_b_q, bin_b_d;
   logic [BIN_W-1:0]   sh_q, sh_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BCD_W-1:0]   dig_a_q, dig_a_d;
   logic [BCD_W-1:0]   dig_b_q, dig_b_d;
   logic [ROW_W-1:0]   row1_q, row1_d;
   logic [ROW_W-1:0]   row2_q, row2_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [BCD_W-1:0]       adj_s;
   logic [BCD_W+BIN_W-1:0] step_s;
   logic                   last_step_s;

   // Builds one row: label, right-aligned digits (MSD first), trailing spaces.
   function automatic logic [ROW_W-1:0] build_row(input logic [31:0]      label,
                                                  input logic [BCD_W-1:0] dig);
      logic [ROW_W-1:0] row;
      logic [3:0]       nib;
      logic             lead;
      row  = {ROW_CHARS{ASCII_SPACE}};
      row[ROW_W-1 -: 32] = label;
      lead = BLANK_LZ;
      for (int i = 0; i < DIGITS; i++) begin
         nib = dig[BCD_W-1-4*i -: 4];
         // Units digit is never blanked so a zero value still shows "0".
         if (lead && (nib == 4'd0) && (i != DIGITS-1)) begin
            row[ROW_W-1-8*(4+i) -: 8] = ASCII_SPACE;
         end else begin
            lead = 1'b0;
            row[ROW_W-1-8*(4+i) -: 8] = ASCII_ZERO + {4'd0, nib};
         end
      end
      return row;
   endfunction

   bcd_add3_adj #(.DIGITS(DIGITS)) u_add3 (
      .bcd_i (bcd_q),
      .bcd_o (adj_s)
   );

   // One double-dabble step: correct, then shift {bcd, bin} left by one.
   always_comb begin
      step_s      = {adj_s, sh_q} << 1;
      last_step_s = (cnt_q == CNT_W'(BIN_W-1));
   end

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      bin_b_d = bin_b_q;
      sh_d    = sh_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      dig_a_d = dig_a_q;
      dig_b_d = dig_b_q;
      row1_d  = row1_q;
      row2_d  = row2_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               bin_b_d = bin_b;
               sh_d    = bin_a;
               bcd_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_CONV_A;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CONV_A: begin
            if (last_step_s) begin
               dig_a_d = step_s[BCD_W+BIN_W-1 -: BCD_W];
               sh_d    = bin_b_q;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = ST_CONV_B;
            end else begin
               bcd_d   = step_s[BCD_W+BIN_W-1 -: BCD_W];
               sh_d    = step_s[BIN_W-1:0];
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         ST_CONV_B: begin
            if (last_step_s) begin
               dig_b_d = step_s[BCD_W+BIN_W-1 -: BCD_W];
               sh_d    = '0;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = ST_UPDATE;
            end else begin
               bcd_d   = step_s[BCD_W+BIN_W-1 -: BCD_W];
               sh_d    = step_s[BIN_W-1:0];
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         ST_UPDATE: begin
            row1_d  = build_row(LABEL_CH1, dig_a_q);
            row2_d  = build_row(LABEL_CH2, dig_b_q);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         bin_b_q <= '0;
         sh_q    <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         dig_a_q <= '0;
         dig_b_q <= '0;
         row1_q  <= {ROW_CHARS{ASCII_SPACE}};
         row2_q  <= {ROW_CHARS{ASCII_SPACE}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bin_b_q <= bin_b_d;
         sh_q    <= sh_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         dig_a_q <= dig_a_d;
         dig_b_q <= dig_b_d;
         row1_q  <= row1_d;
         row2_q  <= row2_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign row1_val = row1_q;
   assign row2_val = row2_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule : lcd_bin2ascii_fmt

// File: tb/tb_lcd_bin2ascii_fmt.sv
// Bench for lcd_bin2ascii_fmt: two instances (leading-zero blanking on/off)
// share stimulus; a cycle-level model predicts all outputs from the
// conversion rules, and literal row strings pin the model.
module tb_lcd_bin2ascii_fmt;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [15:0]  bin_a = 16'd0;
   logic [15:0]  bin_b = 16'd0;
   logic [127:0] r1_b, r2_b, r1_z, r2_z;
   logic         busy_b, done_b, busy_z, done_z;

   int checks = 0;
   int failures = 0;
   int dones = 0;

   localparam logic [127:0] ALL_SP = {16{8'h20}};

   always #5 clk = ~clk;

   lcd_bin2ascii_fmt #(.BIN_W(16), .DIGITS(5), .BLANK_LZ(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .bin_a(bin_a), .bin_b(bin_b),
      .row1_val(r1_b), .row2_val(r2_b), .busy(busy_b), .done(done_b));

   lcd_bin2ascii_fmt #(.BIN_W(16), .DIGITS(5), .BLANK_LZ(1'b0)) dut_z (
      .clk(clk), .rst_n(rst_n), .start(start), .bin_a(bin_a), .bin_b(bin_b),
      .row1_val(r1_z), .row2_val(r2_z), .busy(busy_z), .done(done_z));

   // Expected row text from plain decimal arithmetic.
   function automatic logic [127:0] fmt_row(input int ch, input int v, input bit blank);
      logic [127:0] r;
      int p;
      int d;
      r = ALL_SP;
      r[127:120] = 8'h43;
      r[119:112] = 8'h48;
      r[111:104] = 8'(48 + ch);
      r[103:96]  = 8'h3A;
      p = 10000;
      for (int i = 0; i < 5; i++) begin
         d = (v / p) % 10;
         if (blank && i < 4 && v < p) r[95-8*i -: 8] = 8'h20;
         else                         r[95-8*i -: 8] = 8'(48 + d);
         p = p / 10;
      end
      return r;
   endfunction

   // Model: a request is taken when idle, and results appear 33 edges later.
   int           m_cd;
   int           m_a, m_b;
   logic         m_busy, m_done;
   logic [127:0] m_r1b, m_r2b, m_r1z, m_r2z;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cd <= 0; m_a <= 0; m_b <= 0; m_busy <= 1'b0; m_done <= 1'b0;
         m_r1b <= ALL_SP; m_r2b <= ALL_SP; m_r1z <= ALL_SP; m_r2z <= ALL_SP;
      end else if (m_cd == 0 && start) begin
         m_cd <= 33; m_a <= int'(bin_a); m_b <= int'(bin_b);
         m_busy <= 1'b1; m_done <= 1'b0;
      end else if (m_cd == 1) begin
         m_cd <= 0; m_busy <= 1'b0; m_done <= 1'b1;
         m_r1b <= fmt_row(1, m_a, 1'b1); m_r2b <= fmt_row(2, m_b, 1'b1);
         m_r1z <= fmt_row(1, m_a, 1'b0); m_r2z <= fmt_row(2, m_b, 1'b0);
      end else begin
         if (m_cd > 0) m_cd <= m_cd - 1;
         m_done <= 1'b0;
      end
   end

   task automatic chk_row(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Issues one request and returns edges from accept to visible done.
   task automatic run_conv(input int a, input int b, output int lat);
      start = 1'b1; bin_a = 16'(a); bin_b = 16'(b);
      @(posedge clk);
      #2;
      start = 1'b0; bin_a = 16'($urandom); bin_b = 16'($urandom);
      lat = 1;
      @(posedge clk);
      #1;
      while (!done_b && lat < 60) begin
         @(posedge clk);
         lat++;
         #1;
      end
      #1;
   endtask

   initial begin
      int lat;
      int d0;
      int last_i;
      int nd;
      fork
         forever begin
            @(negedge clk);
            if (done_b) dones++;
            checks++;
            if (r1_b !== m_r1b || r2_b !== m_r2b || busy_b !== m_busy || done_b !== m_done) begin
               failures++;
               $display("FAIL model_blank t=%0t act=%h/%h b%b d%b exp=%h/%h b%b d%b",
                        $time, r1_b, r2_b, busy_b, done_b, m_r1b, m_r2b, m_busy, m_done);
            end
            checks++;
            if (r1_z !== m_r1z || r2_z !== m_r2z || busy_z !== m_busy || done_z !== m_done) begin
               failures++;
               $display("FAIL model_zero t=%0t act=%h/%h b%b d%b exp=%h/%h b%b d%b",
                        $time, r1_z, r2_z, busy_z, done_z, m_r1z, m_r2z, m_busy, m_done);
            end
         end
      join_none

      // Reset state
      tick(3);
      chk_row("reset_row1", r1_b, ALL_SP);
      chk_row("reset_row2", r2_z, ALL_SP);
      chk_int("reset_busy", int'(busy_b), 0);
      chk_int("reset_done", int'(done_b), 0);
      rst_n = 1'b1;
      tick(5);
      chk_int("no_done_without_start", dones, 0);

      // Full scale
      run_conv(0, 65535, lat);
      chk_int("latency_full", lat, 33);
      chk_row("full_r1_blank", r1_b, "CH1:    0       ");
      chk_row("full_r2_blank", r2_b, "CH2:65535       ");
      chk_row("full_r1_zero",  r1_z, "CH1:00000       ");
      chk_row("full_r2_zero",  r2_z, "CH2:65535       ");
      chk_int("full_busy_low", int'(busy_b), 0);
      tick(2);

      // Mixed values
      run_conv(1234, 10, lat);
      chk_int("latency_mixed", lat, 33);
      chk_row("mixed_r1_blank", r1_b, "CH1: 1234       ");
      chk_row("mixed_r2_blank", r2_b, "CH2:   10       ");
      chk_row("mixed_r1_zero",  r1_z, "CH1:01234       ");
      chk_row("mixed_r2_zero",  r2_z, "CH2:00010       ");
      tick(2);

      // Start while busy is ignored
      d0 = dones;
      start = 1'b1; bin_a = 16'd777; bin_b = 16'd5;
      tick(1);
      start = 1'b0;
      tick(4);
      start = 1'b1; bin_a = 16'd999; bin_b = 16'd1;
      tick(1);
      start = 1'b0;
      tick(45);
      chk_int("busy_start_one_done", dones - d0, 1);
      chk_row("busy_start_r1", r1_b, "CH1:  777       ");
      chk_row("busy_start_r2", r2_b, "CH2:    5       ");

      // Back-to-back with start held high
      start = 1'b1; bin_a = 16'd100; bin_b = 16'd200;
      last_i = -1;
      nd = 0;
      for (int i = 1; i <= 110; i++) begin
         tick(1);
         bin_a = bin_a + 16'd1;
         if (done_b) begin
            nd++;
            if (last_i >= 0) chk_int("b2b_spacing", i - last_i, 34);
            last_i = i;
         end
      end
      start = 1'b0;
      chk_int("b2b_count", nd, 3);
      tick(40);

      // Reset mid-conversion
      d0 = dones;
      start = 1'b1; bin_a = 16'd555; bin_b = 16'd7;
      tick(1);
      start = 1'b0;
      tick(19);
      rst_n = 1'b0;
      #1;
      chk_row("midrst_r1", r1_b, ALL_SP);
      chk_row("midrst_r2", r2_b, ALL_SP);
      chk_int("midrst_busy", int'(busy_b), 0);
      tick(2);
      rst_n = 1'b1;
      tick(40);
      chk_int("midrst_no_done", dones - d0, 0);
      run_conv(42, 3, lat);
      chk_int("latency_after_rst", lat, 33);
      chk_row("after_rst_r1_blank", r1_b, "CH1:   42       ");
      chk_row("after_rst_r1_zero",  r1_z, "CH1:00042       ");
      tick(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_lcd_bin2ascii_fmt
